arbiter_weighted: RTL and testbench



---
 rtl/arbiter_weighted.sv | 132 +++++++++++++
 tb/tb_arbiter_weighted.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_weighted.sv
// Weighted round-robin arbiter.
// A rotating one-hot token selects the candidate owner. Each port may hold
// the grant for up to its programmed quantum of consecutive cycles while
// another port is requesting. A weight of 0 counts as 1. Grant, grant_id
// and active are registered one cycle after token/request.
module arbiter_weighted #(
  parameter int NUM_PORTS    = 6,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ID_WIDTH     = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [0:NUM_PORTS-1]              request,
  input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weights,
  output logic [0:NUM_PORTS-1]              grant,
  output logic [ID_WIDTH-1:0]               grant_id,
  output logic                              active
);

  logic [NUM_PORTS-1:0]    token_q, token_d;
  logic [WEIGHT_WIDTH-1:0] count_q, count_d;
  logic [0:NUM_PORTS-1]    grant_q, grant_d;
  logic [ID_WIDTH-1:0]     grant_id_q, grant_id_d;
  logic                    active_q, active_d;

  logic [NUM_PORTS-1:0]    req_vec;
  logic [ID_WIDTH-1:0]     tok_idx;
  logic [WEIGHT_WIDTH-1:0] w_raw;
  logic [WEIGHT_WIDTH-1:0] w_eff;
  logic [WEIGHT_WIDTH-1:0] w_lim;
  logic                    hit;
  logic                    others;
  logic                    expire;
  logic [NUM_PORTS-1:0]    next_tok;
  logic                    next_found;

  // Re-index request so bit i of every internal vector is port i.
  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_vec[i] = request[i];
    end
  end

  // Decode the token owner's index and its live weight field.
  always_comb begin
    tok_idx = '0;
    w_raw   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (token_q[i]) begin
        tok_idx = ID_WIDTH'(i);
        w_raw   = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
  end

  // Quantum terms; a zero weight behaves as a quantum of one cycle.
  always_comb begin
    w_eff  = (w_raw == '0) ? WEIGHT_WIDTH'(1) : w_raw;
    w_lim  = w_eff - WEIGHT_WIDTH'(1);
    hit    = |(token_q & req_vec);
    others = |(req_vec & ~token_q);
    expire = hit & others & (count_q >= w_lim);
  end

  // Look-ahead successor: first requester circularly after the token.
  // The scan ends on the token itself, so with no requester it holds.
  always_comb begin : succ_sel
    int j;
    j          = 0;
    next_tok   = token_q;
    next_found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      j = int'(tok_idx) + k;
      if (j >= NUM_PORTS) begin
        j = j - NUM_PORTS;
      end
      if (!next_found && req_vec[j]) begin
        next_tok    = '0;
        next_tok[j] = 1'b1;
        next_found  = 1'b1;
      end
    end
  end

  // Token and quantum counter next state.
  always_comb begin
    token_d = token_q;
    count_d = count_q;
    if (!hit || expire) begin
      token_d = next_tok;
      count_d = '0;
    end else if (count_q >= w_lim) begin
      // Lone holder: saturate, so a newcomer triggers expiry at once.
      count_d = w_lim;
    end else begin
      count_d = count_q + WEIGHT_WIDTH'(1);
    end
  end

  // Registered outputs follow the current token owner's request.
  always_comb begin
    grant_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant_d[i] = token_q[i] & req_vec[i];
    end
    grant_id_d = hit ? tok_idx : '0;
    active_d   = hit;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      token_q    <= NUM_PORTS'(1);
      count_q    <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      active_q   <= 1'b0;
    end else begin
      token_q    <= token_d;
      count_q    <= count_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      active_q   <= active_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign active   = active_q;

endmodule

// File: tb/tb_arbiter_weighted.sv
// Bench for arbiter_weighted: table vectors, directed multi-cycle
// sequences and random traffic against an index-based reference model.
module tb_arbiter_weighted;

  localparam int NP = 6;
  localparam int WW = 4;
  localparam int IW = 3;
  localparam int WB = NP * WW;

  logic          clk = 1'b0;
  logic          rst;
  logic [0:NP-1] request;
  logic [WB-1:0] weights;
  logic [0:NP-1] grant;
  logic [IW-1:0] grant_id;
  logic          active;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: owner index and cycles served.
  int m_tok = 0;
  int m_cnt = 0;

  typedef struct {
    bit          rn;
    bit [NP-1:0] rq;
    bit [WB-1:0] wt;
    int          exp_id;
  } vec_t;

  vec_t tbl[$];

  arbiter_weighted #(.NUM_PORTS(NP), .WEIGHT_WIDTH(WW), .ID_WIDTH(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .request  (request),
    .weights  (weights),
    .grant    (grant),
    .grant_id (grant_id),
    .active   (active)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected output for this edge from the current model state, then advance the model.
  task automatic model_step(input bit rn, input bit [NP-1:0] rq, input bit [WB-1:0] wt,
                            output int exp_id);
    bit hit, others, expire, found;
    int w, j;
    if (!rn) begin
      exp_id = -1;
      m_tok  = 0;
      m_cnt  = 0;
      return;
    end
    hit    = rq[m_tok];
    w      = int'(wt[m_tok*WW +: WW]);
    if (w == 0) w = 1;
    others = 1'b0;
    for (int p = 0; p < NP; p++) if (p != m_tok && rq[p]) others = 1'b1;
    expire = hit && others && (m_cnt >= w - 1);
    exp_id = hit ? m_tok : -1;
    if (!hit || expire) begin
      found = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        j = (m_tok + k) % NP;
        if (!found && rq[j]) begin
          m_tok = j;
          found = 1'b1;
        end
      end
      m_cnt = 0;
    end else begin
      m_cnt = (m_cnt + 1 > w - 1) ? w - 1 : m_cnt + 1;
    end
  endtask

  task automatic check_out(input string name, input int exp_id);
    logic [0:NP-1] eg;
    logic [IW-1:0] eid;
    logic          eact;
    eg   = '0;
    eid  = '0;
    eact = 1'b0;
    if (exp_id >= 0) begin
      eg[exp_id] = 1'b1;
      eid        = IW'(exp_id);
      eact       = 1'b1;
    end
    n_cmp++;
    if (grant !== eg || grant_id !== eid || active !== eact) begin
      n_bad++;
      $display("FAIL %s @%0t: got grant=%b id=%0d active=%b, required grant=%b id=%0d active=%b",
               name, $time, grant, grant_id, active, eg, eid, eact);
    end
  endtask

  // Drive one cycle of inputs, clock it, and compare with the model.
  task automatic step(input bit rn, input bit [NP-1:0] rq, input bit [WB-1:0] wt,
                      output int mexp);
    rst = rn;
    for (int i = 0; i < NP; i++) request[i] = rq[i];
    weights = wt;
    model_step(rn, rq, wt, mexp);
    @(posedge clk);
    #1;
    check_out("model", mexp);
  endtask

  function automatic vec_t mk(input bit rn, input bit [NP-1:0] rq, input bit [WB-1:0] wt,
                              input int exp_id);
    vec_t v;
    v.rn     = rn;
    v.rq     = rq;
    v.wt     = wt;
    v.exp_id = exp_id;
    return v;
  endfunction

  initial begin
    int          e;
    int          qs_exp[10];
    int          zw_exp[7];
    bit [NP-1:0] rq_r;
    bit [WB-1:0] wt_r;
    bit          rn_r;

    rst     = 1'b0;
    request = '0;
    weights = '0;

    qs_exp = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
    zw_exp = '{0, 1, 2, 3, 4, 5, 0};
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 6'b111111, 24'h000000, -1));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1'b1, 6'b000011, 24'h000032, qs_exp[i]));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(1'b1, 6'b111111, 24'h000000, zw_exp[i]));

    foreach (tbl[i]) begin
      step(tbl[i].rn, tbl[i].rq, tbl[i].wt, e);
      check_out($sformatf("table[%0d]", i), tbl[i].exp_id);
    end

    // Lone holder, then contention, then release with wrap through port 0.
    for (int i = 0; i < 2; i++) step(1'b0, 6'b000000, 24'hF11111, e);
    step(1'b1, 6'b001000, 24'hF11111, e);
    check_out("lone_first_idle", -1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 6'b001000, 24'hF11111, e);
      check_out($sformatf("lone_hold[%0d]", i), 3);
    end
    step(1'b1, 6'b101000, 24'hF11111, e);
    check_out("lone_contend_keep", 3);
    step(1'b1, 6'b101000, 24'hF11111, e);
    check_out("lone_move_to5", 5);
    step(1'b1, 6'b000010, 24'hF11111, e);
    check_out("release_idle", -1);
    step(1'b1, 6'b000010, 24'hF11111, e);
    check_out("wrap_grant1", 1);

    // Live weight drop mid-burst, then reset during a grant.
    step(1'b0, 6'b000000, 24'h010800, e);
    step(1'b1, 6'b010100, 24'h010800, e);
    check_out("burst_idle", -1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 6'b010100, 24'h010800, e);
      check_out($sformatf("burst_p2[%0d]", i), 2);
    end
    step(1'b1, 6'b010100, 24'h010200, e);
    check_out("wdrop_last_p2", 2);
    step(1'b1, 6'b010100, 24'h010200, e);
    check_out("wdrop_switch_p4", 4);
    step(1'b0, 6'b111111, 24'h010200, e);
    check_out("midburst_reset", -1);
    step(1'b1, 6'b111111, 24'h010200, e);
    check_out("post_reset_p0", 0);

    // Random traffic against the model.
    rq_r = 6'b111111;
    wt_r = 24'h123456;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 2) == 0) begin
          rq_r = '0;
          rq_r[$urandom_range(0, NP - 1)] = 1'b1;
        end else begin
          rq_r = NP'($urandom);
        end
      end
      if ($urandom_range(0, 15) == 0) wt_r = WB'($urandom);
      rn_r = ($urandom_range(0, 199) != 0);
      step(rn_r, rq_r, wt_r, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
